// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl
//
// Built-in self-test controller for a 2-input combinational cell (NOR2 by
// default). It walks {A2,A1} through 00,01,11,10 for PASSES passes. After each
// vector change it waits SETTLE cycles, then samples ZN. The sample is checked
// against the truth table TT and folded into a MISR signature.
//
// Ports
//   CLK     in   clock, rising edge
//   RN      in   asynchronous active-low reset
//   START   in   begin a run (honoured in IDLE or DONE)
//   ABORT   in   stop the current run (honoured in RUN only)
//   ZN      in   output of the cell under test
//   A1, A2  out  registered cell inputs
//   BUSY    out  run in progress
//   DONE    out  run completed, held until the next START
//   PASS    out  DONE with zero mismatches
//   ERR_CNT out  saturating mismatch count
//   SIG     out  MISR signature of the sampled ZN stream
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl #(
  parameter logic [3:0]       TT       = 4'b0001,
  parameter int               SETTLE   = 2,
  parameter int               PASSES   = 4,
  parameter int               CNT_W    = 8,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [SIG_W-1:0] SIG
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] SETTLE_L  = 4'(SETTLE);
  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_t           r_state, w_state_nxt;
  logic             r_a1, r_a2, r_busy, r_done;
  logic             w_a1_nxt, w_a2_nxt, w_busy_nxt, w_done_nxt;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic [SIG_W-1:0] r_sig, w_sig_nxt;
  logic [1:0]       r_vidx, w_vidx_nxt, w_vidx_inc;
  logic [7:0]       r_pass, w_pass_nxt;
  logic [3:0]       r_settle, w_settle_nxt;
  logic             w_exp, w_mis, w_zn_bit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic b);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0)
           ^ {{(SIG_W-1){1'b0}}, b};
  endfunction

  // Vector index to {A2,A1}: binary-to-Gray, so one input toggles per step.
  function automatic logic [1:0] gray(input logic [1:0] idx);
    return {idx[1], idx[1] ^ idx[0]};
  endfunction

  assign w_exp      = TT[{r_a2, r_a1}];
  // Case equality so an X/Z on ZN reads as a mismatch and injects a 1.
  assign w_mis      = (ZN !== w_exp);
  assign w_zn_bit   = (ZN === 1'b0) ? 1'b0 : 1'b1;
  assign w_vidx_inc = r_vidx + 2'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_a1_nxt     = r_a1;
    w_a2_nxt     = r_a2;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;
    w_sig_nxt    = r_sig;
    w_vidx_nxt   = r_vidx;
    w_pass_nxt   = r_pass;
    w_settle_nxt = r_settle;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) begin
          w_state_nxt  = S_RUN;
          w_busy_nxt   = 1'b1;
          w_done_nxt   = 1'b0;
          w_err_nxt    = '0;
          w_sig_nxt    = '1;
          w_vidx_nxt   = 2'd0;
          w_a1_nxt     = 1'b0;
          w_a2_nxt     = 1'b0;
          w_settle_nxt = SETTLE_L;
          w_pass_nxt   = 8'd0;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_a1_nxt    = 1'b0;
          w_a2_nxt    = 1'b0;
          w_vidx_nxt  = 2'd0;
        end else if (r_settle != 4'd0) begin
          w_settle_nxt = r_settle - 4'd1;
        end else begin
          if (w_mis) w_err_nxt = sat_inc(r_err);
          w_sig_nxt    = misr_step(r_sig, w_zn_bit);
          w_settle_nxt = SETTLE_L;
          w_vidx_nxt   = w_vidx_inc;
          {w_a2_nxt, w_a1_nxt} = gray(w_vidx_inc);
          if (r_vidx == 2'd3) begin
            w_pass_nxt = r_pass + 8'd1;
            if (r_pass == LAST_PASS) begin
              w_state_nxt = S_DONE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_a1_nxt    = 1'b0;
              w_a2_nxt    = 1'b0;
              w_vidx_nxt  = 2'd0;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state  <= S_IDLE;
      r_a1     <= 1'b0;
      r_a2     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= '0;
      r_sig    <= '1;
      r_vidx   <= 2'd0;
      r_pass   <= 8'd0;
      r_settle <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_a1     <= w_a1_nxt;
      r_a2     <= w_a2_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_sig    <= w_sig_nxt;
      r_vidx   <= w_vidx_nxt;
      r_pass   <= w_pass_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  assign A1      = r_a1;
  assign A2      = r_a2;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign PASS    = r_done && (r_err == '0);
  assign ERR_CNT = r_err;
  assign SIG     = r_sig;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl.
// dut0: default parameters, ZN selectable (NOR2 model / stuck-0 / stuck-1).
// dut1: CNT_W=2, ZN stuck at 1.
// dut2: SETTLE=0, PASSES=1, ZN from a correct NOR2 model.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl;

  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic lo = 1'b0;
  logic hi = 1'b1;

  // dut0
  logic        st0, ab0, zn0;
  int          mode0;
  logic        a1_0, a2_0, busy0, done0, pass0;
  logic [7:0]  err0;
  logic [15:0] sig0;
  assign zn0 = (mode0 == 0) ? ~(a1_0 | a2_0) : (mode0 == 1) ? 1'b0 : 1'b1;

  gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl u_dut0 (
    .CLK(clk), .RN(rn), .START(st0), .ABORT(ab0), .ZN(zn0),
    .A1(a1_0), .A2(a2_0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .SIG(sig0)
  );

  // dut1
  logic        st1;
  logic        a1_1, a2_1, busy1, done1, pass1;
  logic [1:0]  err1;
  logic [15:0] sig1;

  gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl #(.CNT_W(2)) u_dut1 (
    .CLK(clk), .RN(rn), .START(st1), .ABORT(lo), .ZN(hi),
    .A1(a1_1), .A2(a2_1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .SIG(sig1)
  );

  // dut2
  logic        st2, zn2;
  logic        a1_2, a2_2, busy2, done2, pass2;
  logic [7:0]  err2;
  logic [15:0] sig2;
  assign zn2 = ~(a1_2 | a2_2);

  gf180mcu_fd_sc_mcu9t5v0__bist2_ctrl #(.SETTLE(0), .PASSES(1)) u_dut2 (
    .CLK(clk), .RN(rn), .START(st2), .ABORT(lo), .ZN(zn2),
    .A1(a1_2), .A2(a2_2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err2), .SIG(sig2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, b};
  endfunction

  function automatic logic [1:0] vec_of(input int idx);
    logic [1:0] v;
    case (idx % 4)
      0: v = 2'b00;
      1: v = 2'b01;
      2: v = 2'b11;
      default: v = 2'b10;
    endcase
    return v;
  endfunction

  // Expected signature after nsteps samples with ZN per mode (0 NOR2, 1 stuck0, 2 stuck1).
  function automatic logic [15:0] gold(input int nsteps, input int mode);
    logic [15:0] s;
    logic [1:0]  v;
    logic        z;
    s = 16'hFFFF;
    for (int i = 0; i < nsteps; i++) begin
      v = vec_of(i);
      z = (mode == 0) ? ~(v[0] | v[1]) : (mode == 1) ? 1'b0 : 1'b1;
      s = misr(s, z);
    end
    return s;
  endfunction

  // Start a dut0 run and finish it, checking DONE rises exactly 48 edges after START.
  task automatic run0(input int mode);
    mode0 = mode;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    check("run_start_done_clr", done0, 1'b0);
    check("run_start_busy", busy0, 1'b1);
    repeat (47) tick();
    check("run_done_early", done0, 1'b0);
    tick();
    check("run_done_48", done0, 1'b1);
    check("run_busy_end", busy0, 1'b0);
  endtask

  initial begin
    rn = 1'b0; st0 = 1'b0; ab0 = 1'b0; st1 = 1'b0; st2 = 1'b0; mode0 = 0;
    repeat (2) tick();
    // Reset state
    check("rst_a", {a2_0, a1_0}, 2'b00);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_pass", pass0, 1'b0);
    check("rst_err", err0, 8'd0);
    check("rst_sig", sig0, 16'hFFFF);
    @(negedge clk);
    rn = 1'b1;
    tick();

    // 1: correct NOR2, vector sequence and golden signature
    mode0 = 0;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    for (int n = 0; n < 48; n++) begin
      check("t1_vec", {a2_0, a1_0}, vec_of(n / 3));
      check("t1_busy", busy0, 1'b1);
      check("t1_done", done0, 1'b0);
      tick();
    end
    check("t1_done48", done0, 1'b1);
    check("t1_pass", pass0, 1'b1);
    check("t1_err", err0, 8'd0);
    check("t1_a", {a2_0, a1_0}, 2'b00);
    check("t1_sig", sig0, gold(16, 0));

    // 2: stuck-at faults
    run0(1);
    check("t2_s0_err", err0, 8'd4);
    check("t2_s0_pass", pass0, 1'b0);
    check("t2_s0_sig", sig0, gold(16, 1));
    run0(2);
    check("t2_s1_err", err0, 8'd12);
    check("t2_s1_pass", pass0, 1'b0);
    check("t2_s1_sig", sig0, gold(16, 2));

    // 4: ABORT at cycle 20 with stuck-1, then clean restart
    mode0 = 2;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (19) tick();
    ab0 = 1'b1;
    tick();
    ab0 = 1'b0;
    check("t4_busy", busy0, 1'b0);
    check("t4_done", done0, 1'b0);
    check("t4_a", {a2_0, a1_0}, 2'b00);
    check("t4_err_hold", err0, 8'd4);
    check("t4_sig_hold", sig0, gold(6, 2));
    repeat (3) tick();
    check("t4_idle_busy", busy0, 1'b0);
    check("t4_idle_done", done0, 1'b0);
    mode0 = 0;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    check("t4_re_err", err0, 8'd0);
    check("t4_re_sig", sig0, 16'hFFFF);
    check("t4_re_busy", busy0, 1'b1);
    repeat (47) tick();
    check("t4_re_early", done0, 1'b0);
    tick();
    check("t4_re_done", done0, 1'b1);
    check("t4_re_pass", pass0, 1'b1);
    ab0 = 1'b1;
    tick();
    ab0 = 1'b0;
    check("t4_abort_in_done", done0, 1'b1);
    check("t4_pass_in_done", pass0, 1'b1);

    // 5: asynchronous reset mid-run, then START ignored during RUN
    mode0 = 2;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (29) tick();
    check("t5_err_pre", err0, 8'd6);
    #2 rn = 1'b0;
    #1;
    check("t5_busy", busy0, 1'b0);
    check("t5_done", done0, 1'b0);
    check("t5_pass", pass0, 1'b0);
    check("t5_a", {a2_0, a1_0}, 2'b00);
    check("t5_err", err0, 8'd0);
    check("t5_sig", sig0, 16'hFFFF);
    @(negedge clk);
    rn = 1'b1;
    tick();
    check("t5_idle", busy0, 1'b0);
    mode0 = 0;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (9) tick();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    check("t5_busy_st", busy0, 1'b1);
    repeat (14) tick();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (22) tick();
    check("t5_early", done0, 1'b0);
    tick();
    check("t5_done48", done0, 1'b1);
    check("t5_pass48", pass0, 1'b1);

    // 3: CNT_W=2 saturation
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    check("t3_busy", busy1, 1'b1);
    repeat (47) tick();
    check("t3_early", done1, 1'b0);
    tick();
    check("t3_done48", done1, 1'b1);
    check("t3_err_sat", err1, 2'd3);
    check("t3_pass", pass1, 1'b0);
    check("t3_sig", sig1, gold(16, 2));
    check("t3_a", {a2_1, a1_1}, 2'b00);

    // 6: SETTLE=0, PASSES=1, and restart from DONE
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check("t6_vec", {a2_2, a1_2}, vec_of(n));
      check("t6_done", done2, 1'b0);
      tick();
    end
    check("t6_done4", done2, 1'b1);
    check("t6_pass", pass2, 1'b1);
    check("t6_busy", busy2, 1'b0);
    check("t6_err", err2, 8'd0);
    check("t6_sig", sig2, gold(4, 0));
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    check("t6_re_clr", done2, 1'b0);
    check("t6_re_busy", busy2, 1'b1);
    repeat (3) tick();
    check("t6_re_early", done2, 1'b0);
    tick();
    check("t6_re_done", done2, 1'b1);
    check("t6_re_pass", pass2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
